fetch_predecode: RTL and testbench

- Stage-1 fetch front end that owns the fetch PC and issues one instruction-memory request at a time.
- Pre-decodes each returned word for JAL/JALR/branch and predicts the next PC.
- Drives the push/pop/replace/flush controls and write data of the return address stack, and reads its top-of-stack.
- Hands {instr, pc, predicted pc} to decode over a valid/ready handshake.

---
 rtl/fetch_predecode.sv | 170 +++++++++++++++++
 tb/tb_fetch_predecode.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_predecode.sv
// fetch_predecode: single-outstanding fetch front end with JAL/JALR/branch
// pre-decode, next-PC prediction and return-address-stack control.
// Optional build macro: BTFN_PREDICT_EN (backward-taken/forward-not-taken
// prediction for conditional branches; otherwise branches predict not-taken).
module fetch_predecode #(
    parameter logic [47:0] RESET_PC = 48'h0,
    parameter bit          LINK_X5  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [47:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [47:0] out_pc,
    output logic [47:0] out_pred_pc,
    input  logic        redirect,
    input  logic [47:0] redirect_pc,
    output logic        ras_push,
    output logic        ras_pop,
    output logic        ras_replace,
    output logic        ras_flush,
    output logic [47:0] ras_idata,
    input  logic [47:0] ras_odata
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t             state, state_next;
    logic [47:0]        pc, pc_next, pc_plus4;
    logic               drain, drain_next;
    logic               capture;
    logic [6:0]         opcode;
    logic [4:0]         rd, rs1;
    logic               link_rd, link_rs1;
    logic signed [47:0] imm_j;
`ifdef BTFN_PREDICT_EN
    logic signed [47:0] imm_b;
`endif
    logic [47:0]        pred_pc;
    logic               push_d, pop_d, repl_d;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (LINK_X5 && (r == 5'd5));
    endfunction

    assign opcode   = imem_rdata[6:0];
    assign rd       = imem_rdata[11:7];
    assign rs1      = imem_rdata[19:15];
    assign link_rd  = is_link(rd);
    assign link_rs1 = is_link(rs1);
    assign pc_plus4 = pc + 48'd4;
    assign imm_j    = {{27{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                       imem_rdata[20], imem_rdata[30:21], 1'b0};
`ifdef BTFN_PREDICT_EN
    assign imm_b    = {{35{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                       imem_rdata[30:25], imem_rdata[11:8], 1'b0};
`endif

    // Pre-decode the returned word into a predicted PC and a RAS action
    always_comb begin
        pred_pc = pc_plus4;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        repl_d  = 1'b0;
        case (opcode)
            7'b1101111: begin
                pred_pc = pc + $unsigned(imm_j);
                push_d  = link_rd;
            end
            7'b1100111: begin
                if (link_rd && !link_rs1) begin
                    push_d = 1'b1;
                end else if (!link_rd && link_rs1) begin
                    pop_d   = 1'b1;
                    pred_pc = ras_odata;
                end else if (link_rd && link_rs1) begin
                    // Same register on both sides is a fresh call, not a coroutine swap
                    if (rd == rs1) begin
                        push_d = 1'b1;
                    end else begin
                        repl_d  = 1'b1;
                        pred_pc = ras_odata;
                    end
                end
            end
            7'b1100011: begin
`ifdef BTFN_PREDICT_EN
                if (imem_rdata[31]) pred_pc = pc + $unsigned(imm_b);
`endif
            end
            default: ;
        endcase
    end

    // Next-state, next-PC and drain tracking; redirect overrides everything
    always_comb begin
        state_next = state;
        pc_next    = pc;
        drain_next = drain;
        if (redirect) begin
            pc_next    = redirect_pc;
            state_next = FETCH;
            // A request still in flight must have its response swallowed
            drain_next = (state == FETCH) && !imem_valid;
        end else begin
            case (state)
                IDLE:  state_next = FETCH;
                FETCH: begin
                    if (imem_valid) begin
                        if (drain) drain_next = 1'b0;
                        else       state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        pc_next    = out_pred_pc;
                        state_next = FETCH;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign capture     = (state == FETCH) && imem_valid && !drain && !redirect;
    assign imem_req    = (state == FETCH) && !drain;
    assign imem_addr   = pc;
    assign ras_push    = capture && push_d;
    assign ras_pop     = capture && pop_d;
    assign ras_replace = capture && repl_d;
    assign ras_flush   = redirect;
    assign ras_idata   = capture ? pc_plus4 : 48'h0;

    // Control state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            drain <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            drain <= drain_next;
        end
    end

    // Decode handoff register: load on capture, release on handshake or redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_pc      <= 48'h0;
            out_pred_pc <= 48'h0;
        end else if (redirect) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid   <= 1'b1;
            out_instr   <= imem_rdata;
            out_pc      <= pc;
            out_pred_pc <= pred_pc;
        end else if ((state == HOLD) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_predecode.sv
// tb_fetch_predecode: directed bench for fetch_predecode (RESET_PC=0x1000, LINK_X5=1).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fetch_predecode;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [47:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [47:0] out_pc;
    logic [47:0] out_pred_pc;
    logic        redirect;
    logic [47:0] redirect_pc;
    logic        ras_push, ras_pop, ras_replace, ras_flush;
    logic [47:0] ras_idata;
    logic [47:0] ras_odata;

    int errors = 0;
    int checks = 0;

    fetch_predecode #(.RESET_PC(48'h1000), .LINK_X5(1'b1)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pred_pc(out_pred_pc),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ras_push(ras_push), .ras_pop(ras_pop), .ras_replace(ras_replace),
        .ras_flush(ras_flush), .ras_idata(ras_idata), .ras_odata(ras_odata)
    );

    always #5 clk = ~clk;

    // Redirect while a request is outstanding, feed one response that must be
    // discarded, then expect the new request. Entered and left at a falling edge.
    task automatic redirect_drain(input logic [47:0] addr);
        redirect = 1'b1; redirect_pc = addr; #1;
        checks++; if (ras_flush !== 1'b1) begin errors++; $display("FAIL flush_same_cycle: got %b want 1", ras_flush); end
        @(negedge clk); redirect = 1'b0; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_req: got %b want 0", imem_req); end
        imem_valid = 1'b1; imem_rdata = 32'h100000EF; #1;
        checks++; if ({ras_push, ras_pop, ras_replace} !== 3'b000) begin errors++; $display("FAIL drain_ras: got %b want 000", {ras_push, ras_pop, ras_replace}); end
        @(negedge clk); imem_valid = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_outvalid: got %b want 0", out_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== addr) begin errors++; $display("FAIL drain_reissue: got req=%b addr=%h want 1 %h", imem_req, imem_addr, addr); end
    endtask

    // Return one response word; report the RAS outputs seen in the capture cycle
    task automatic fetch(input logic [31:0] word, input logic [47:0] tos,
                         output logic [2:0] ras, output logic [47:0] idata);
        imem_valid = 1'b1; imem_rdata = word; ras_odata = tos; #1;
        ras = {ras_push, ras_pop, ras_replace}; idata = ras_idata;
        @(negedge clk); imem_valid = 1'b0; #1;
    endtask

    // Hand the held instruction to decode; the next request must target exp_addr
    task automatic handoff(input logic [47:0] exp_addr);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b want 1", out_valid); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL handoff_clear: got %b want 0", out_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin errors++; $display("FAIL next_fetch: got req=%b addr=%h want 1 %h", imem_req, imem_addr, exp_addr); end
    endtask

    // Compare one captured instruction against its expected result
    task automatic expect_cap(input string nm, input logic [2:0] ras, input logic [2:0] exp_ras,
                              input logic [47:0] idata, input logic [47:0] exp_idata,
                              input logic [47:0] pc, input logic [47:0] pred, input logic [31:0] word);
        checks++; if (ras !== exp_ras) begin errors++; $display("FAIL %s_ras: got %b want %b", nm, ras, exp_ras); end
        checks++; if (idata !== exp_idata) begin errors++; $display("FAIL %s_idata: got %h want %h", nm, idata, exp_idata); end
        checks++; if (out_pred_pc !== pred) begin errors++; $display("FAIL %s_pred: got %h want %h", nm, out_pred_pc, pred); end
        checks++; if (out_pc !== pc || out_instr !== word) begin errors++; $display("FAIL %s_out: got pc=%h instr=%h want %h %h", nm, out_pc, out_instr, pc, word); end
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_valid = 1'b0; imem_rdata = 32'h0; out_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 48'h0; ras_odata = 48'h0;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (imem_addr !== 48'h1000) begin errors++; $display("FAIL reset_addr: got %h want 1000", imem_addr); end
        checks++; if ({imem_req, out_valid} !== 2'b00) begin errors++; $display("FAIL reset_ctl: got %b want 00", {imem_req, out_valid}); end
        checks++; if ({ras_push, ras_pop, ras_replace, ras_flush} !== 4'b0 || ras_idata !== 48'h0) begin errors++; $display("FAIL reset_ras: got %b %h want 0000 0", {ras_push, ras_pop, ras_replace, ras_flush}, ras_idata); end
        checks++; if (out_pred_pc !== 48'h0 || out_pc !== 48'h0 || out_instr !== 32'h0) begin errors++; $display("FAIL reset_out: got %h %h %h want 0", out_pred_pc, out_pc, out_instr); end
        @(negedge clk); reset = 1'b0; #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", imem_req); end
        @(negedge clk); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 48'h1000) begin errors++; $display("FAIL first_req: got %b %h want 1 1000", imem_req, imem_addr); end
    endtask

    task automatic test_jal();
        logic [2:0] r; logic [47:0] d;
        redirect_drain(48'h2000);
        fetch(32'h100000EF, 48'h0, r, d);            // jal x1, +0x100
        expect_cap("jal", r, 3'b100, d, 48'h2004, 48'h2000, 48'h2100, 32'h100000EF);
        handoff(48'h2100);
    endtask

    task automatic test_jalr();
        logic [2:0] r; logic [47:0] d;
        fetch(32'h00008067, 48'h2004, r, d);         // jalr x0, 0(x1): return
        expect_cap("ret", r, 3'b010, d, 48'h2104, 48'h2100, 48'h2004, 32'h00008067);
        handoff(48'h2004);
        fetch(32'h000082E7, 48'h5550, r, d);         // jalr x5, 0(x1): coroutine swap
        expect_cap("swap", r, 3'b001, d, 48'h2008, 48'h2004, 48'h5550, 32'h000082E7);
        handoff(48'h5550);
        fetch(32'h000080E7, 48'h0, r, d);            // jalr x1, 0(x1): call
        expect_cap("call", r, 3'b100, d, 48'h5554, 48'h5550, 48'h5554, 32'h000080E7);
        handoff(48'h5554);
        fetch(32'h00030067, 48'h1234, r, d);         // jalr x0, 0(x6): plain jump
        expect_cap("jmp", r, 3'b000, d, 48'h5558, 48'h5554, 48'h5558, 32'h00030067);
        handoff(48'h5558);
    endtask

    task automatic test_branch();
        logic [2:0] r; logic [47:0] d; logic [47:0] bt;
`ifdef BTFN_PREDICT_EN
        bt = 48'h3000;
`else
        bt = 48'h300C;
`endif
        redirect_drain(48'h3008);
        fetch(32'hFE000CE3, 48'h0, r, d);            // beq x0, x0, -8
        expect_cap("bwd", r, 3'b000, d, 48'h300C, 48'h3008, bt, 32'hFE000CE3);
        handoff(bt);
        fetch(32'h00000463, 48'h0, r, d);            // beq x0, x0, +8
        expect_cap("fwd", r, 3'b000, d, bt + 48'd4, bt, bt + 48'd4, 32'h00000463);
        handoff(bt + 48'd4);
    endtask

    task automatic test_stall();
        logic [2:0] r; logic [47:0] d;
        redirect_drain(48'h4000);
        fetch(32'h100000EF, 48'h0, r, d);
        expect_cap("stall", r, 3'b100, d, 48'h4004, 48'h4000, 48'h4100, 32'h100000EF);
        for (int i = 0; i < 5; i++) begin
            // A stray response while holding must be ignored
            imem_valid = (i == 2); imem_rdata = 32'h00008067; #1;
            checks++;
            if (out_valid !== 1'b1 || out_instr !== 32'h100000EF || out_pred_pc !== 48'h4100 ||
                imem_req !== 1'b0 || {ras_push, ras_pop, ras_replace} !== 3'b000) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b instr=%h pred=%h req=%b ras=%b want 1 100000ef 4100 0 000",
                         i, out_valid, out_instr, out_pred_pc, imem_req, {ras_push, ras_pop, ras_replace});
            end
            @(negedge clk); imem_valid = 1'b0;
        end
        #1;
        handoff(48'h4100);
    endtask

    task automatic test_wrap();
        logic [2:0] r; logic [47:0] d;
        redirect_drain(48'hFFFF_FFFF_FFFC);
        fetch(32'h00000013, 48'h0, r, d);            // addi x0, x0, 0
        expect_cap("wrap", r, 3'b000, d, 48'h0, 48'hFFFF_FFFF_FFFC, 48'h0, 32'h00000013);
        handoff(48'h0);
    endtask

    task automatic test_redirect();
        logic [2:0] r; logic [47:0] d;
        redirect_drain(48'h8000);
        // Response and redirect together: capture and RAS pulse suppressed, no drain
        imem_valid = 1'b1; imem_rdata = 32'h100000EF; redirect = 1'b1; redirect_pc = 48'hA000; #1;
        checks++; if ({ras_push, ras_flush} !== 2'b01) begin errors++; $display("FAIL redir_cap_ras: got %b want 01", {ras_push, ras_flush}); end
        @(negedge clk); imem_valid = 1'b0; redirect = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 48'hA000) begin errors++; $display("FAIL redir_cap_next: got v=%b req=%b addr=%h want 0 1 a000", out_valid, imem_req, imem_addr); end
        // Redirect in HOLD beats a simultaneous out_ready
        fetch(32'h00000013, 48'h0, r, d);
        redirect = 1'b1; redirect_pc = 48'hB000; out_ready = 1'b1; #1;
        checks++; if (ras_flush !== 1'b1) begin errors++; $display("FAIL redir_hold_flush: got %b want 1", ras_flush); end
        @(negedge clk); redirect = 1'b0; out_ready = 1'b0; #1;
        checks++; if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 48'hB000) begin errors++; $display("FAIL redir_hold_next: got v=%b req=%b addr=%h want 0 1 b000", out_valid, imem_req, imem_addr); end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_jal();
        test_jalr();
        test_branch();
        test_stall();
        test_wrap();
        test_redirect();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
